l2_bus_arbiter: RTL and testbench
=================================

Name: l2_bus_arbiter

Overview:
- Shared-bus front end that sits directly upstream of the L2 cache subsystem.
- Collects load/store requests from NUM_CORES L1/core ports and selects one per transaction by round-robin.
- Drives the selected request onto the L2 bus (opcode, address, write data) for exactly one cycle, captures the L2 result (data, hit/miss code), and returns it to the winning core with a one-cycle done pulse.

Parameters:
- NUM_CORES, 2: number of requesting cores; legal range 2..8.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- core_req  in  NUM_CORES  per-core request; held high until that core's core_done.
- core_opcode  in  NUM_CORES*7  per-core RISC-V opcode; slice i = [7i+6:7i].
- core_addr  in  NUM_CORES*ADDR_W  per-core byte address.
- core_wdata  in  NUM_CORES*DATA_W  per-core store data.
- core_grant  out  NUM_CORES  one-hot; high for the core owning the bus (ISSUE and RESP states).
- core_done  out  NUM_CORES  one-hot, one-cycle completion pulse.
- core_rdata  out  DATA_W  captured L2 load data; valid while core_done is high.
- core_hit  out  2  captured L2 hit code (10 hit, 01 miss, 00 no-op); valid with core_done.
- opcode_out  out  7  opcode to L2; 7'b0 whenever not in ISSUE.
- bus_address_out  out  ADDR_W  address to L2.
- bus_data_out  out  DATA_W  store data to L2.
- data_from_L2  in  DATA_W  L2 combinational load data.
- cache_hit_in  in  2  L2 combinational hit code.
- busy  out  1  high in ISSUE or RESP.

Behaviour:
- Reset (async, reset low): state IDLE; all outputs 0; rr pointer = NUM_CORES-1, so core 0 wins first.
- Because opcode_out is 0, the L2 performs no write during reset or mid-transaction reset.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any core_req is set, select winner w = first set bit searching from pointer+1 with wrap.
  - Latch w, its opcode, address and wdata into registers; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - opcode_out, bus_address_out and bus_data_out come from the latched registers.
  - The L2 writes on the negedge inside this cycle.
  - At posedge: capture data_from_L2 into core_rdata and cache_hit_in into core_hit; pointer = w; go to RESP.
- RESP (exactly 1 cycle):
  - core_done[w] = 1 and opcode_out = 0.
  - Next state is always IDLE. No back-to-back issue.
- Latency and throughput:
  - Request visible in IDLE at cycle 0 → ISSUE in cycle 1 → core_done in cycle 2.
  - Throughput is 1 transaction per 3 cycles.
- Opcodes:
  - Only 7'b0000011 (load) and 7'b0100011 (store) are forwarded.
  - Any other opcode is latched as 0: the transaction completes normally with core_hit = 00 and core_rdata = 0.
- Store data: core_rdata for a store is don't-care and is driven 0. core_hit reflects cache_hit_in, which the L2 drives 00 for stores.
- Request handshake:
  - The core must deassert core_req in the cycle after core_done.
  - A req still high in the IDLE after RESP is treated as a new request, but round-robin gives other pending cores priority first.
- Request changes while not granted: core_req, core_opcode, core_addr and core_wdata changes are ignored until arbitration. The latched copy is immune to changes after the IDLE sample.
- core_grant stays constant and one-hot from ISSUE through RESP.

Optional Feature:
- Macro: L2_BUS_SNOOP_EN.
- When defined: adds outputs snoop_valid (1) and snoop_addr (ADDR_W).
  - In ISSUE of a store, snoop_valid = 1 and snoop_addr = latched address.
  - This is broadcast to all cores; non-granted cores invalidate matching L1 lines, and the granted core ignores it.
  - snoop_valid is 0 in all other states and cycles.
- When undefined: no snoop ports exist and behaviour is otherwise identical.

Decomposition:
- Package l2_bus_pkg holds:
  - OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011, OPC_NOP = 7'b0.
  - HIT_CODE_HIT = 2'b10, HIT_CODE_MISS = 2'b01, HIT_CODE_NONE = 2'b00.
  - The typedef enum for states IDLE/ISSUE/RESP.
- Sub-module rr_arbiter (parameter N):
  - Combinational winner select from req and pointer; registered pointer update on an update strobe.
  - Same async active-low reset.

Test Plan:
- Core0 only, load addr 0x0000_0104, L2 drives 0xDEAD_BEEF/10 → opcode_out = 0000011 only in cycle 1; core_done[0] in cycle 2 with rdata 0xDEAD_BEEF, hit 10.
- Both cores request in the same cycle from reset → core0 served first, then core1; with both held, grants alternate 0,1,0,1.
- Core1 store 0x0000_0200 data 0x1234_5678 → bus_data_out = 0x1234_5678 in ISSUE only; core_hit 00; with L2_BUS_SNOOP_EN, snoop_valid pulses with snoop_addr 0x0000_0200.
- Illegal opcode 7'b0110011 from core0 → opcode_out stays 0 throughout; core_done after 2 cycles with hit 00 and rdata 0.
- Reset asserted low during ISSUE → all outputs 0 immediately (async); after release core0 wins the next arbitration.
- Load miss (cache_hit_in = 01, data 0) → core_hit 01 and rdata 0 on done; next request is accepted in the following IDLE.

Source files
------------

// File: rtl/l2_bus_pkg.sv
// Shared constants and types for the L2 bus arbiter.
// Holds opcode encodings, hit codes and the FSM state type.
package l2_bus_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_NOP   = 7'b0000000;

    localparam logic [1:0] HIT_CODE_HIT  = 2'b10;
    localparam logic [1:0] HIT_CODE_MISS = 2'b01;
    localparam logic [1:0] HIT_CODE_NONE = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Only loads and stores reach the L2; anything else becomes a no-op.
    function automatic logic [6:0] filter_opc(input logic [6:0] opc);
        return (opc == OPC_LOAD || opc == OPC_STORE) ? opc : OPC_NOP;
    endfunction

endpackage

// File: rtl/l2_bus_arbiter_rr.sv
// Round-robin winner select for the L2 bus arbiter.
// Pointer holds the last winner; search starts one past it.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          update,
    input  logic [IW-1:0] next_ptr,
    output logic          any,
    output logic [IW-1:0] winner
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;

    // First requester after the pointer, wrapping around.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

    // Reset points at the last core so core 0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= IW'(N - 1);
        end else if (update) begin
            ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/l2_bus_arbiter.sv
// Round-robin front end between NUM_CORES cores and the L2 bus.
// Optional store snoop broadcast: define L2_BUS_SNOOP_EN.
module l2_bus_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES*7-1:0]      core_opcode,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_grant,
    output logic [NUM_CORES-1:0]        core_done,
    output logic [DATA_W-1:0]           core_rdata,
    output logic [1:0]                  core_hit,
    output logic [6:0]                  opcode_out,
    output logic [ADDR_W-1:0]           bus_address_out,
    output logic [DATA_W-1:0]           bus_data_out,
    input  logic [DATA_W-1:0]           data_from_L2,
    input  logic [1:0]                  cache_hit_in,
`ifdef L2_BUS_SNOOP_EN
    output logic                        snoop_valid,
    output logic [ADDR_W-1:0]           snoop_addr,
`endif
    output logic                        busy
);

    import l2_bus_pkg::*;

    localparam int IW = $clog2(NUM_CORES);

    state_t        state;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] gnt_idx;
    logic          req_any;
    logic          ptr_upd;
    logic [6:0]    lat_opc;
    logic [6:0]    sel_opc;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign ptr_upd = (state == ISSUE);

    rr_arbiter #(.N(NUM_CORES)) u_rr (
        .clk      (clk),
        .reset    (reset),
        .req      (core_req),
        .update   (ptr_upd),
        .next_ptr (gnt_idx),
        .any      (req_any),
        .winner   (win_idx)
    );

    // Mux the winning core's request fields, illegal opcodes squashed.
    always_comb begin
        sel_opc   = OPC_NOP;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (win_idx == IW'(i)) begin
                sel_opc   = filter_opc(core_opcode[i*7 +: 7]);
                sel_addr  = core_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = core_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // IDLE -> ISSUE -> RESP transaction FSM with registered bus outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            gnt_idx         <= '0;
            lat_opc         <= OPC_NOP;
            core_grant      <= '0;
            core_done       <= '0;
            core_rdata      <= '0;
            core_hit        <= HIT_CODE_NONE;
            opcode_out      <= OPC_NOP;
            bus_address_out <= '0;
            bus_data_out    <= '0;
            busy            <= 1'b0;
`ifdef L2_BUS_SNOOP_EN
            snoop_valid     <= 1'b0;
            snoop_addr      <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_any) begin
                        state           <= ISSUE;
                        gnt_idx         <= win_idx;
                        lat_opc         <= sel_opc;
                        opcode_out      <= sel_opc;
                        bus_address_out <= sel_addr;
                        bus_data_out    <= sel_wdata;
                        core_grant      <= NUM_CORES'(1) << win_idx;
                        busy            <= 1'b1;
`ifdef L2_BUS_SNOOP_EN
                        snoop_valid     <= (sel_opc == OPC_STORE);
                        snoop_addr      <= (sel_opc == OPC_STORE) ? sel_addr : '0;
`endif
                    end
                end
                ISSUE: begin
                    state           <= RESP;
                    opcode_out      <= OPC_NOP;
                    bus_address_out <= '0;
                    bus_data_out    <= '0;
                    core_done       <= core_grant;
                    core_rdata      <= (lat_opc == OPC_LOAD) ? data_from_L2 : '0;
                    core_hit        <= (lat_opc == OPC_NOP) ? HIT_CODE_NONE : cache_hit_in;
`ifdef L2_BUS_SNOOP_EN
                    snoop_valid     <= 1'b0;
                    snoop_addr      <= '0;
`endif
                end
                RESP: begin
                    state      <= IDLE;
                    core_done  <= '0;
                    core_grant <= '0;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Self-checking bench for l2_bus_arbiter.
// Directed scenarios plus a randomized run against a schedule model.
module tb_l2_bus_arbiter;

    import l2_bus_pkg::*;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk;
    logic            reset;
    logic [N-1:0]    core_req;
    logic [N*7-1:0]  core_opcode;
    logic [N*AW-1:0] core_addr;
    logic [N*DW-1:0] core_wdata;
    logic [N-1:0]    core_grant;
    logic [N-1:0]    core_done;
    logic [DW-1:0]   core_rdata;
    logic [1:0]      core_hit;
    logic [6:0]      opcode_out;
    logic [AW-1:0]   bus_address_out;
    logic [DW-1:0]   bus_data_out;
    logic [DW-1:0]   data_from_L2;
    logic [1:0]      cache_hit_in;
    logic            busy;
`ifdef L2_BUS_SNOOP_EN
    logic            snoop_valid;
    logic [AW-1:0]   snoop_addr;
`endif

    int tests;
    int failed;

    l2_bus_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .core_req        (core_req),
        .core_opcode     (core_opcode),
        .core_addr       (core_addr),
        .core_wdata      (core_wdata),
        .core_grant      (core_grant),
        .core_done       (core_done),
        .core_rdata      (core_rdata),
        .core_hit        (core_hit),
        .opcode_out      (opcode_out),
        .bus_address_out (bus_address_out),
        .bus_data_out    (bus_data_out),
        .data_from_L2    (data_from_L2),
        .cache_hit_in    (cache_hit_in),
`ifdef L2_BUS_SNOOP_EN
        .snoop_valid     (snoop_valid),
        .snoop_addr      (snoop_addr),
`endif
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int i, input logic [6:0] op,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_opcode[i*7 +: 7] = op;
        core_addr[i*AW +: AW] = a;
        core_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        core_req = '0;
        core_opcode = '0;
        core_addr = '0;
        core_wdata = '0;
        data_from_L2 = '0;
        cache_hit_in = 2'b00;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        reset = 1'b0;
        core_req = '1;
        for (int i = 0; i < N; i++) set_core(i, OPC_LOAD, 32'h40 * i, 32'h1);
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if ({core_grant, core_done, core_rdata, core_hit, opcode_out,
                 bus_address_out, bus_data_out, busy} !== '0) begin
                failed++;
                $display("FAIL reset_outputs: cycle %0d grant=%b done=%b opc=%b busy=%b want all 0",
                         c, core_grant, core_done, opcode_out, busy);
            end
        end
        core_req = '0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load;
        do_reset();
        set_core(0, OPC_LOAD, 32'h0000_0104, 32'h0);
        core_req = 3'b001;
        tick();
        tests++;
        if ({opcode_out, bus_address_out} !== {OPC_LOAD, 32'h0000_0104}) begin
            failed++;
            $display("FAIL load_issue_bus: got opc=%b addr=%h want 0000011/00000104",
                     opcode_out, bus_address_out);
        end
        tests++;
        if ({core_grant, busy, core_done} !== {3'b001, 1'b1, 3'b000}) begin
            failed++;
            $display("FAIL load_issue_ctl: got grant=%b busy=%b done=%b want 001/1/000",
                     core_grant, busy, core_done);
        end
        data_from_L2 = 32'hDEAD_BEEF;
        cache_hit_in = HIT_CODE_HIT;
        tick();
        tests++;
        if ({core_done, core_grant, opcode_out} !== {3'b001, 3'b001, OPC_NOP}) begin
            failed++;
            $display("FAIL load_resp_ctl: got done=%b grant=%b opc=%b want 001/001/0",
                     core_done, core_grant, opcode_out);
        end
        tests++;
        if ({core_rdata, core_hit} !== {32'hDEAD_BEEF, HIT_CODE_HIT}) begin
            failed++;
            $display("FAIL load_resp_data: got rdata=%h hit=%b want deadbeef/10",
                     core_rdata, core_hit);
        end
        core_req = '0;
        data_from_L2 = '0;
        cache_hit_in = 2'b00;
        tick();
        tests++;
        if ({core_grant, core_done, busy} !== '0) begin
            failed++;
            $display("FAIL load_back_idle: got grant=%b done=%b busy=%b want 0",
                     core_grant, core_done, busy);
        end
    endtask

    task automatic test_alternate;
        int order[$];
        int want[4];
        want = '{0, 1, 0, 1};
        do_reset();
        set_core(0, OPC_LOAD, 32'h10, 32'h0);
        set_core(1, OPC_LOAD, 32'h20, 32'h0);
        core_req = 3'b011;
        for (int c = 0; c < 12; c++) begin
            tick();
            for (int i = 0; i < N; i++) if (core_done[i]) order.push_back(i);
        end
        core_req = '0;
        tests++;
        if (order.size() != 4) begin
            failed++;
            $display("FAIL alt_count: got %0d dones want 4", order.size());
        end
        for (int k = 0; k < 4 && k < order.size(); k++) begin
            tests++;
            if (order[k] != want[k]) begin
                failed++;
                $display("FAIL alt_order[%0d]: got core %0d want core %0d",
                         k, order[k], want[k]);
            end
        end
        tick();
        tick();
    endtask

    task automatic test_store;
        do_reset();
        set_core(1, OPC_STORE, 32'h0000_0200, 32'h1234_5678);
        core_req = 3'b010;
        tick();
        tests++;
        if ({opcode_out, bus_address_out, bus_data_out, core_grant} !==
            {OPC_STORE, 32'h0000_0200, 32'h1234_5678, 3'b010}) begin
            failed++;
            $display("FAIL store_issue: got opc=%b addr=%h data=%h grant=%b",
                     opcode_out, bus_address_out, bus_data_out, core_grant);
        end
`ifdef L2_BUS_SNOOP_EN
        tests++;
        if ({snoop_valid, snoop_addr} !== {1'b1, 32'h0000_0200}) begin
            failed++;
            $display("FAIL store_snoop: got v=%b addr=%h want 1/00000200",
                     snoop_valid, snoop_addr);
        end
`endif
        data_from_L2 = 32'hAAAA_5555;
        cache_hit_in = HIT_CODE_NONE;
        tick();
        tests++;
        if ({core_done, core_hit, core_rdata, bus_data_out} !==
            {3'b010, 2'b00, 32'h0, 32'h0}) begin
            failed++;
            $display("FAIL store_resp: got done=%b hit=%b rdata=%h bdata=%h want 010/00/0/0",
                     core_done, core_hit, core_rdata, bus_data_out);
        end
`ifdef L2_BUS_SNOOP_EN
        tests++;
        if (snoop_valid !== 1'b0) begin
            failed++;
            $display("FAIL store_snoop_off: got %b want 0", snoop_valid);
        end
`endif
        core_req = '0;
        tick();
    endtask

    task automatic test_illegal;
        do_reset();
        set_core(0, 7'b0110011, 32'h0000_0300, 32'h5);
        core_req = 3'b001;
        data_from_L2 = 32'hFFFF_FFFF;
        cache_hit_in = HIT_CODE_HIT;
        for (int c = 1; c <= 3; c++) begin
            tick();
            tests++;
            if (opcode_out !== 7'b0) begin
                failed++;
                $display("FAIL illegal_opc: cycle %0d got %b want 0", c, opcode_out);
            end
            if (c == 2) begin
                tests++;
                if ({core_done, core_hit, core_rdata} !== {3'b001, 2'b00, 32'h0}) begin
                    failed++;
                    $display("FAIL illegal_resp: got done=%b hit=%b rdata=%h want 001/00/0",
                             core_done, core_hit, core_rdata);
                end
                core_req = '0;
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        set_core(0, OPC_LOAD, 32'h50, 32'h0);
        set_core(1, OPC_STORE, 32'h60, 32'h7);
        core_req = 3'b001;
        tick();
        tick();
        core_req = '0;
        tick();
        core_req = 3'b010;
        tick();
        tests++;
        if (core_grant !== 3'b010) begin
            failed++;
            $display("FAIL midrst_pre_grant: got %b want 010", core_grant);
        end
        #1 reset = 1'b0;
        #1;
        tests++;
        if ({core_grant, busy, opcode_out, bus_address_out, bus_data_out} !== '0) begin
            failed++;
            $display("FAIL midrst_async: got grant=%b busy=%b opc=%b want 0",
                     core_grant, busy, opcode_out);
        end
        tick();
        reset = 1'b1;
        core_req = 3'b011;
        tick();
        tests++;
        if (core_grant !== 3'b001) begin
            failed++;
            $display("FAIL midrst_first_winner: got %b want 001", core_grant);
        end
        core_req = '0;
        tick();
        tick();
    endtask

    task automatic test_miss;
        do_reset();
        set_core(0, OPC_LOAD, 32'h300, 32'h0);
        core_req = 3'b001;
        tick();
        data_from_L2 = 32'h0;
        cache_hit_in = HIT_CODE_MISS;
        tick();
        tests++;
        if ({core_done, core_hit, core_rdata} !== {3'b001, HIT_CODE_MISS, 32'h0}) begin
            failed++;
            $display("FAIL miss_resp: got done=%b hit=%b rdata=%h want 001/01/0",
                     core_done, core_hit, core_rdata);
        end
        core_req = 3'b010;
        set_core(1, OPC_LOAD, 32'h400, 32'h0);
        tick();
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL miss_idle: got busy=%b want 0", busy);
        end
        tick();
        tests++;
        if ({core_grant, opcode_out, bus_address_out} !== {3'b010, OPC_LOAD, 32'h400}) begin
            failed++;
            $display("FAIL miss_next_issue: got grant=%b opc=%b addr=%h want 010/0000011/400",
                     core_grant, opcode_out, bus_address_out);
        end
        core_req = '0;
        tick();
        tick();
    endtask

    task automatic test_random;
        int last;
        int issue_c;
        int done_c;
        int w;
        int r;
        logic [N-1:0] oh;
        logic [6:0] eop;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [DW-1:0] erd;
        logic [1:0] ehit;
        logic [6:0] rop;
        do_reset();
        last = N - 1;
        issue_c = -1;
        done_c = -1;
        w = 0;
        eop = '0; ea = '0; ed = '0; erd = '0; ehit = '0;
        for (int k = 0; k < 600; k++) begin
            oh = '0;
            oh[w] = 1'b1;
            data_from_L2 = $urandom;
            cache_hit_in = 2'($urandom_range(0, 2));
            tests++;
            if (k == issue_c) begin
                if ({core_grant, busy, core_done, opcode_out, bus_address_out, bus_data_out}
                    !== {oh, 1'b1, {N{1'b0}}, eop, ea, ed}) begin
                    failed++;
                    $display("FAIL rand_issue: k=%0d grant=%b opc=%b addr=%h data=%h want %b/%b/%h/%h",
                             k, core_grant, opcode_out, bus_address_out, bus_data_out,
                             oh, eop, ea, ed);
                end
                erd = (eop == OPC_LOAD) ? data_from_L2 : '0;
                ehit = (eop == OPC_NOP) ? 2'b00 : cache_hit_in;
`ifdef L2_BUS_SNOOP_EN
                tests++;
                if (snoop_valid !== (eop == OPC_STORE)) begin
                    failed++;
                    $display("FAIL rand_snoop: k=%0d got %b", k, snoop_valid);
                end
`endif
            end else if (k == done_c) begin
                if ({core_grant, busy, core_done, opcode_out, core_rdata, core_hit}
                    !== {oh, 1'b1, oh, 7'b0, erd, ehit}) begin
                    failed++;
                    $display("FAIL rand_done: k=%0d done=%b rdata=%h hit=%b want %b/%h/%b",
                             k, core_done, core_rdata, core_hit, oh, erd, ehit);
                end
                core_req[w] = 1'b0;
            end else begin
                if ({core_grant, busy, core_done, opcode_out} !== '0) begin
                    failed++;
                    $display("FAIL rand_idle: k=%0d grant=%b busy=%b done=%b opc=%b",
                             k, core_grant, busy, core_done, opcode_out);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!core_req[i] && !(k == done_c && i == w) && $urandom_range(0, 3) == 0)
                    core_req[i] = 1'b1;
                r = int'($urandom_range(0, 3));
                rop = 7'($urandom);
                if (r < 2) rop = OPC_LOAD;
                else if (r == 2) rop = OPC_STORE;
                set_core(i, rop, $urandom, $urandom);
            end
            if (k != issue_c && k != done_c && core_req != '0) begin
                for (int j = 1; j <= N; j++) begin
                    if (core_req[(last + j) % N]) begin
                        w = (last + j) % N;
                        break;
                    end
                end
                last = w;
                issue_c = k + 1;
                done_c = k + 2;
                eop = core_opcode[w*7 +: 7];
                if (eop != OPC_LOAD && eop != OPC_STORE) eop = 7'b0;
                ea = core_addr[w*AW +: AW];
                ed = core_wdata[w*DW +: DW];
            end
            tick();
        end
        core_req = '0;
        tick();
        tick();
    endtask

    initial begin
        tests = 0;
        failed = 0;
        reset = 1'b0;
        core_req = '0;
        core_opcode = '0;
        core_addr = '0;
        core_wdata = '0;
        data_from_L2 = '0;
        cache_hit_in = 2'b00;
        test_reset();
        test_load();
        test_alternate();
        test_store();
        test_illegal();
        test_reset_mid();
        test_miss();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
